// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int DIV_MAX_W = 32;

  // A bit period shorter than two clocks cannot be timed, so 0 and 1 run as 2.
  function automatic logic [DIV_MAX_W-1:0] div_eff(input logic [DIV_MAX_W-1:0] d);
    logic [DIV_MAX_W-1:0] r;
    r = (d < DIV_MAX_W'(2)) ? DIV_MAX_W'(2) : d;
    return r;
  endfunction

  function automatic parity_t parity_decode(input logic [1:0] p);
    parity_t r;
    case (p)
      2'b01:   r = PAR_EVEN;
      2'b10:   r = PAR_ODD;
      default: r = PAR_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Character write port of the UART transmitter.
// A character transfers on a rising clk edge where s_valid and s_ready are both high;
// s_data must be stable while s_valid is high, and s_ready does not depend on s_valid.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         full,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [LW-1:0]    level_n;
  logic             do_wr, do_rd;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // The wrap bit lets the pointer difference span 0..DEPTH without ambiguity.
  always_comb begin
    wr_ptr_n = wr_ptr + PW'(do_wr);
    rd_ptr_n = rd_ptr + PW'(do_rd);
    level_n  = LW'(wr_ptr_n - rd_ptr_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      full   <= (level_n == LW'(DEPTH));
      empty  <= (level_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO, runtime divisor, character length, parity and stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int DIV_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_fifo_if.slave               s,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic [3:0]                  cfg_bits,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
  output state_t                      dbg_state
);
  localparam int BW = $clog2(DATA_W + 1);

  function automatic logic [BW-1:0] bits_eff(input logic [3:0] b);
    logic [BW-1:0] r;
    if (b >= 4'd5 && 32'(b) <= DATA_W) r = BW'(b);
    else                               r = BW'(DATA_W);
    return r;
  endfunction

  state_t            state;
  logic [DIV_W-1:0]  cnt, div_sh;
  logic [BW-1:0]     bit_idx, bits_sh;
  logic              stop_idx, stop2_sh;
  parity_t           par_sh;
  logic              par_acc;
  logic [DATA_W-1:0] shreg;

  logic              fifo_full, fifo_empty, pop, bit_end, stop_last;
  logic [DATA_W-1:0] fifo_data;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (s.s_valid),
    .wr_data (s.s_data),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign s.s_ready = ~fifo_full;
  assign dbg_state = state;

  assign bit_end   = (cnt == div_sh - DIV_W'(1));
  assign stop_last = (stop_idx == stop2_sh);
  // Popping on the last stop clock chains frames with no idle gap.
  assign pop = ~fifo_empty &
               ((state == ST_IDLE) | ((state == ST_STOP) & bit_end & stop_last));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      par_acc    <= 1'b0;
      shreg      <= '0;
      div_sh     <= DIV_W'(2);
      bits_sh    <= BW'(DATA_W);
      par_sh     <= PAR_NONE;
      stop2_sh   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) begin
        state    <= ST_START;
        tx       <= 1'b0;
        busy     <= 1'b1;
        cnt      <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        par_acc  <= 1'b0;
        shreg    <= fifo_data;
        div_sh   <= DIV_W'(div_eff(DIV_MAX_W'(cfg_div)));
        bits_sh  <= bits_eff(cfg_bits);
        par_sh   <= parity_decode(cfg_parity);
        stop2_sh <= cfg_stop2;
      end else if (state != ST_IDLE) begin
        if (!bit_end) begin
          cnt        <= cnt + DIV_W'(1);
          // Registered pulse lands on the final clock of the last stop bit.
          frame_done <= (state == ST_STOP) && stop_last && (cnt + DIV_W'(2) == div_sh);
        end else begin
          cnt <= '0;
          case (state)
            ST_START: begin
              state   <= ST_DATA;
              tx      <= shreg[0];
              par_acc <= par_acc ^ shreg[0];
              shreg   <= shreg >> 1;
            end
            ST_DATA: begin
              if (bit_idx == bits_sh - BW'(1)) begin
                if (par_sh == PAR_NONE) begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
                end else begin
                  state <= ST_PARITY;
                  tx    <= (par_sh == PAR_ODD) ? ~par_acc : par_acc;
                end
              end else begin
                bit_idx <= bit_idx + BW'(1);
                tx      <= shreg[0];
                par_acc <= par_acc ^ shreg[0];
                shreg   <= shreg >> 1;
              end
            end
            ST_PARITY: begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end
            ST_STOP: begin
              if (stop_last) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                stop_idx <= 1'b1;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, hand sequences and random frames against a line-level model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int DIV_W  = 16;
  localparam int LW     = $clog2(DEPTH + 1);

  typedef struct {
    int                div;
    int                bits;
    int                par;
    int                stop2;
    logic [DATA_W-1:0] data;
  } frame_t;

  typedef struct {
    int                div;
    int                bits;
    int                par;
    int                stop2;
    logic [DATA_W-1:0] data;
    int                exp_len;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [3:0]        cfg_bits = 4'd8;
  logic [1:0]        cfg_parity = 2'b00;
  logic              cfg_stop2 = 1'b0;
  logic              tx, busy, frame_done;
  logic [LW-1:0]     fifo_level;
  state_t            dbg_state;

  uart_tx_fifo_if #(.DATA_W(DATA_W)) bus ();

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (bus.slave),
    .cfg_div    (cfg_div),
    .cfg_bits   (cfg_bits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_level (fifo_level),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int eff_bits(input int b);
    return (b >= 5 && b <= DATA_W) ? b : DATA_W;
  endfunction

  function automatic int frame_len(input frame_t f);
    int n;
    n = 1 + eff_bits(f.bits) + ((f.par == 1 || f.par == 2) ? 1 : 0) + (f.stop2 != 0 ? 2 : 1);
    return n * eff_div(f.div);
  endfunction

  logic mon_wave[$];

  // Expected tx level for every clock of the frame.
  task automatic build_wave(input frame_t f);
    logic sym[$];
    int   ones;
    ones = 0;
    sym.push_back(1'b0);
    for (int i = 0; i < eff_bits(f.bits); i++) begin
      sym.push_back(f.data[i]);
      ones += int'(f.data[i]);
    end
    if (f.par == 1) sym.push_back((ones % 2) == 1);
    if (f.par == 2) sym.push_back((ones % 2) == 0);
    sym.push_back(1'b1);
    if (f.stop2 != 0) sym.push_back(1'b1);
    mon_wave.delete();
    foreach (sym[k]) begin
      for (int j = 0; j < eff_div(f.div); j++) mon_wave.push_back(sym[k]);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  frame_t exp_q[$];
  int     gap_q[$];
  frame_t mon_f;
  bit     mon_active = 1'b0;
  bit     ghost_seen = 1'b0;
  int     mon_pos = 0, mon_err = 0, first_bad = 0, mon_start = 0;
  int     prev_end = -1000;
  int     frames_done = 0;
  int     fd_total = 0;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else begin
      if (frame_done === 1'b1) fd_total++;
      if (!mon_active && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          if (!ghost_seen) begin
            checks++;
            fails++;
            $display("FAIL unexpected_frame: tx low at cycle %0d with no character queued", cyc);
          end
          ghost_seen = 1'b1;
        end else begin
          mon_f = exp_q.pop_front();
          build_wave(mon_f);
          mon_active = 1'b1;
          mon_pos    = 0;
          mon_err    = 0;
          mon_start  = cyc;
          gap_q.push_back(cyc - prev_end - 1);
        end
      end
      if (mon_active) begin
        if (tx !== mon_wave[mon_pos] || busy !== 1'b1 ||
            frame_done !== ((mon_pos == int'(mon_wave.size()) - 1) ? 1'b1 : 1'b0)) begin
          if (mon_err == 0) first_bad = mon_pos;
          mon_err++;
        end
        mon_pos++;
        if (mon_pos == int'(mon_wave.size())) begin
          checks++;
          if (mon_err != 0) begin
            fails++;
            $display("FAIL frame_%0d: data %02h, %0d of %0d clocks wrong, first at clock %0d (required 0 wrong)",
                     frames_done, mon_f.data, mon_err, mon_wave.size(), first_bad);
          end
          frames_done++;
          prev_end   = cyc;
          mon_active = 1'b0;
        end
      end
    end
  end

  int busy_run = 0;
  int last_busy_len = 0;
  always @(negedge clk) begin
    if (reset) busy_run = 0;
    else if (busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  int last_write_cyc = 0;

  task automatic write_char(input logic [DATA_W-1:0] d, input int div_tag);
    int     n;
    frame_t f;
    n = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (bus.s_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("write_accept", int'(bus.s_ready === 1'b1), 1);
    last_write_cyc = cyc;
    f = '{(div_tag < 0) ? int'(cfg_div) : div_tag, int'(cfg_bits), int'(cfg_parity),
          int'(cfg_stop2), d};
    exp_q.push_back(f);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic set_cfg(input int d, input int b, input int p, input int s2);
    cfg_div    = DIV_W'(d);
    cfg_bits   = 4'(b);
    cfg_parity = 2'(p);
    cfg_stop2  = 1'(s2);
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(frames_done >= target), 1);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[8];

  initial begin
    int     base, fd_base, accepted, mg, n;
    frame_t f;
    logic [DATA_W-1:0] d;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    vecs[0] = '{4, 8,  0, 0, 8'hA5, 40};
    vecs[1] = '{4, 7,  1, 1, 8'h53, 44};
    vecs[2] = '{4, 7,  2, 1, 8'h53, 44};
    vecs[3] = '{0, 8,  0, 0, 8'h3C, 20};
    vecs[4] = '{1, 5,  3, 0, 8'h1F, 14};
    vecs[5] = '{2, 15, 1, 0, 8'hFF, 22};
    vecs[6] = '{3, 4,  2, 1, 8'h81, 36};
    vecs[7] = '{5, 6,  1, 0, 8'hC7, 45};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_tx",         int'(tx), 1);
    check("reset_busy",       int'(busy), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_level",      int'(fifo_level), 0);
    check("reset_s_ready",    int'(bus.s_ready), 1);
    check("reset_state",      int'(dbg_state), int'(ST_IDLE));

    // Single frames from the vector table.
    foreach (vecs[i]) begin
      set_cfg(vecs[i].div, vecs[i].bits, vecs[i].par, vecs[i].stop2);
      base    = frames_done;
      fd_base = fd_total;
      write_char(vecs[i].data, -1);
      wait_frames($sformatf("vec%0d_done", i), base + 1, 400);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_busy_len", i), last_busy_len, vecs[i].exp_len);
      check($sformatf("vec%0d_done_pulses", i), fd_total - fd_base, 1);
      check($sformatf("vec%0d_idle_tx", i), int'(tx), 1);
      if (i == 0) check("start_latency", mon_start - last_write_cyc, 2);
    end

    // Burst past capacity; the first character leaves for the shifter one clock after it lands.
    set_cfg(2, 8, 0, 0);
    base = frames_done;
    gap_q.delete();
    accepted = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = DATA_W'(i * 37 + 11);
      if (bus.s_ready === 1'b1) begin
        accepted++;
        exp_q.push_back('{2, 8, 0, 0, DATA_W'(i * 37 + 11)});
      end
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    check("burst_accepted", accepted, DEPTH + 1);
    check("burst_level",    int'(fifo_level), DEPTH);
    check("burst_s_ready",  int'(bus.s_ready), 0);
    wait_frames("burst_done", base + DEPTH + 1, 1500);
    mg = 0;
    for (int k = 1; k < gap_q.size(); k++) if (gap_q[k] > mg) mg = gap_q[k];
    check("burst_frames", gap_q.size(), DEPTH + 1);
    check("burst_max_gap", mg, 0);

    // Divisor change while a frame is on the line.
    set_cfg(4, 8, 0, 0);
    base = frames_done;
    write_char(8'h3A, -1);
    write_char(8'hC5, 8);
    n = 0;
    while (!mon_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("div_change_started", int'(mon_active), 1);
    repeat (8) @(negedge clk);
    cfg_div = DIV_W'(8);
    wait_frames("div_change_done", base + 2, 400);
    repeat (2) @(negedge clk);
    check("div_change_busy_len", last_busy_len, 40 + 80);

    // Reset during the data bits of the second of three frames.
    set_cfg(4, 8, 0, 0);
    base = frames_done;
    write_char(8'h11, -1);
    write_char(8'h22, -1);
    write_char(8'h33, -1);
    wait_frames("abort_first_done", base + 1, 300);
    repeat (12) @(negedge clk);
    check("abort_level_before", int'(fifo_level), 1);
    check("abort_busy_before",  int'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("abort_tx",    int'(tx), 1);
    check("abort_busy",  int'(busy), 0);
    check("abort_level", int'(fifo_level), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = frames_done;
    repeat (120) @(negedge clk);
    check("abort_no_frames", frames_done - base, 0);
    check("abort_idle_tx",   int'(tx), 1);
    check("abort_idle_busy", int'(busy), 0);

    // Random single frames with random configuration.
    for (int r = 0; r < 20; r++) begin
      set_cfg($urandom_range(0, 6), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
      d = DATA_W'($urandom);
      f = '{int'(cfg_div), int'(cfg_bits), int'(cfg_parity), int'(cfg_stop2), d};
      base = frames_done;
      write_char(d, -1);
      wait_frames($sformatf("rand%0d_done", r), base + 1, 300);
      repeat (2) @(negedge clk);
      check($sformatf("rand%0d_busy_len", r), last_busy_len, frame_len(f));
    end

    // Random burst with gaps between writes.
    set_cfg($urandom_range(2, 5), $urandom_range(5, 8), $urandom_range(0, 3), $urandom_range(0, 1));
    base = frames_done;
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      write_char(DATA_W'($urandom), -1);
    end
    wait_frames("rand_burst_done", base + 8, 1500);

    repeat (4) @(negedge clk);
    check("frame_done_total", fd_total, frames_done);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
